ds_adc_decimator: RTL and testbench

//  Receive side of the team's first-order delta-sigma link: a 1-bit delta-sigma ADC front end.
//  - Samples an external comparator and drives the 1-bit feedback DAC pin.
//  - Decimates the bitstream with a 3rd-order CIC (sinc^3) filter.
//  - Emits signed OUT_W-bit samples with a one-cycle valid strobe.
//  - Sits between the comparator/RC pins and the sample-processing logic.

---
 rtl/ds_pkg.sv | 18 +
 rtl/ds_sync2.sv | 33 +++
 rtl/ds_adc_decimator.sv | 185 ++++++++++++++++++
 tb/tb_ds_adc_decimator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// ds_pkg: definitions shared by the delta-sigma receive path.
//   CIC_ORDER    number of integrator/comb sections in the decimator (sinc^3)
//   cic_width()  signed CIC register width for a decimation ratio of 2**dec_log2:
//                order*log2(R) bits of growth, one sign bit and one bit for the
//                +/-1 input
//   ds_sample_t  signed container wide enough for the largest legal output sample
package ds_pkg;

    localparam int CIC_ORDER    = 3;
    localparam int SAMPLE_W_MAX = 16;

    typedef logic signed [SAMPLE_W_MAX-1:0] ds_sample_t;

    function automatic int cic_width(input int dec_log2);
        return 1 + CIC_ORDER * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/ds_sync2.sv
// ds_sync2: two-flop synchroniser for a single asynchronous input bit.
//   clk   in   system clock, rising edge
//   clrn  in   asynchronous active-low clear, both flops go to 0
//   d     in   asynchronous input
//   q     out  synchronised copy of d, two clk edges late
module ds_sync2 (
    input  logic clk,
    input  logic clrn,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ds_adc_decimator.sv
// ds_adc_decimator: 1-bit delta-sigma ADC receive path.
// Synchronises the comparator, drives the feedback DAC pin from the synchronised
// bit, and decimates the +/-1 bitstream by R = 2**DEC_LOG2 with a sinc^3 CIC.
//
// Ports
//   clk           in   system clock, rising edge
//   clrn          in   asynchronous active-low reset; clears every register
//   cmp_in        in   comparator output, asynchronous to clk
//   fb_out        out  feedback DAC drive (synchronised comparator bit)
//   sample_out    out  signed OUT_W-bit decimated sample, held between strobes
//   sample_valid  out  one-cycle strobe when sample_out/sat update
//   sat           out  1 when the last sample was clamped
//
// Output contract: sample_valid is a strobe, not a handshake. There is no ready
// and no back-pressure; the consumer must take sample_out (and sat) in the cycle
// sample_valid is high. Strobes are exactly R clocks apart once warm-up is over.
//
// Build option
//   DS_DEC_ROUND_EN  defined: round half up before the output shift;
//                    undefined: truncating arithmetic shift.
module ds_adc_decimator
    import ds_pkg::*;
#(
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = 8
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    cmp_in,
    output logic                    fb_out,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    sat
);

    localparam int W     = cic_width(DEC_LOG2);
    // One extra bit so the rounding offset can never wrap the comb result.
    localparam int WE    = W + 1;
    localparam int SHIFT = CIC_ORDER * DEC_LOG2 - (OUT_W - 1);

    localparam logic signed [WE-1:0] Y_MAX = WE'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [WE-1:0] Y_MIN = -(WE'(1) <<< (OUT_W - 1));

`ifdef DS_DEC_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WE-1:0] RND = (SHIFT > 0) ? (WE'(1) << RND_POS) : WE'(0);
`endif

    // ------------------------------------------------------------------
    // Comparator synchroniser; its second flop is also the DAC drive.
    // ------------------------------------------------------------------
    logic s;

    ds_sync2 u_sync (
        .clk  (clk),
        .clrn (clrn),
        .d    (cmp_in),
        .q    (s)
    );

    assign fb_out = s;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [W-1:0]     i1_q, i1_d;
    logic signed [W-1:0]     i2_q, i2_d;
    logic signed [W-1:0]     i3_q, i3_d;
    logic signed [W-1:0]     d1_q, d1_d;
    logic signed [W-1:0]     d2_q, d2_d;
    logic signed [W-1:0]     d3_q, d3_d;
    logic [DEC_LOG2-1:0]     cnt_q, cnt_d;
    logic [1:0]              wu_q, wu_d;
    logic signed [OUT_W-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [W-1:0]  x;
    logic                 tick;
    logic                 warm;
    logic signed [W-1:0]  c1, c2, c3;
    logic signed [WE-1:0] pre;
    logic signed [WE-1:0] y;
    logic signed [WE-1:0] y_clamp;
    logic                 clamp;

    always_comb begin
        // 1 means positive: +1, otherwise -1 (all ones).
        x = s ? W'(1) : '1;

        // Each integrator accumulates the previous stage's registered value;
        // wrap-around is harmless because the combs undo it.
        i1_d = i1_q + x;
        i2_d = i2_q + i1_q;
        i3_d = i3_q + i2_q;

        cnt_d = cnt_q + DEC_LOG2'(1);
        tick  = &cnt_q;
        warm  = (wu_q == 2'd3);

        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;

        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        if (tick) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
        end

        // Ticks before the fourth only count; the combs still settle meanwhile.
        wu_d = wu_q;
        if (tick && !warm) begin
            wu_d = wu_q + 2'd1;
        end
    end

    always_comb begin
`ifdef DS_DEC_ROUND_EN
        pre = WE'(c3) + RND;
`else
        pre = WE'(c3);
`endif
        y = pre >>> SHIFT;

        y_clamp = y;
        clamp   = 1'b0;
        if (y > Y_MAX) begin
            y_clamp = Y_MAX;
            clamp   = 1'b1;
        end else if (y < Y_MIN) begin
            y_clamp = Y_MIN;
            clamp   = 1'b1;
        end
    end

    always_comb begin
        valid_d  = tick && warm;
        sample_d = sample_q;
        sat_d    = sat_q;
        if (valid_d) begin
            sample_d = OUT_W'(y_clamp);
            sat_d    = clamp;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            cnt_q    <= '0;
            wu_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            cnt_q    <= cnt_d;
            wu_q     <= wu_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_ds_adc_decimator.sv
// Testbench for ds_adc_decimator (DEC_LOG2=6, OUT_W=8).
// The reference model works on whole numbers: cumulative sums of the +/-1
// stream, decimated, then the third finite difference of the decimated sums.
module tb_ds_adc_decimator;
    import ds_pkg::*;

    localparam int     DEC_LOG2 = 6;
    localparam int     OUT_W    = 8;
    localparam int     R        = 1 << DEC_LOG2;
    localparam int     SHIFT    = 3 * DEC_LOG2 - (OUT_W - 1);
    localparam longint Y_MAX    = (1 << (OUT_W - 1)) - 1;
    localparam longint Y_MIN    = -(1 << (OUT_W - 1));

    // ---------------- clock / reset / DUT ----------------
    logic                    clk    = 1'b0;
    logic                    clrn   = 1'b1;
    logic                    cmp_in = 1'b0;
    logic                    fb_out;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    sat;

    always #5 clk = ~clk;

    ds_adc_decimator #(
        .DEC_LOG2 (DEC_LOG2),
        .OUT_W    (OUT_W)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .cmp_in       (cmp_in),
        .fb_out       (fb_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sat          (sat)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic signed [63:0] act,
                               input longint lo, input longint hi);
        n_cmp++;
        if ($isunknown(act) || act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    bit         cmp_hist[$];   // cmp_in as sampled on each edge since release
    longint     dec_i3[$];     // triple running sum captured on each tick
    longint     i1, i2, i3;
    int         edges;         // edges since reset release
    int         ticks;
    bit         exp_valid;
    ds_sample_t exp_sample;
    bit         exp_sat;
    bit         exp_fb;

    function automatic longint dv(input int k);
        return (k >= 0) ? dec_i3[k] : 64'sd0;
    endfunction

    task automatic model_reset();
        cmp_hist.delete();
        dec_i3.delete();
        i1 = 0; i2 = 0; i3 = 0;
        edges      = 0;
        ticks      = 0;
        exp_valid  = 1'b0;
        exp_sample = '0;
        exp_sat    = 1'b0;
        exp_fb     = 1'b0;
    endtask

    // One rising edge: outputs expected just after it.
    task automatic model_step();
        bit     s;
        longint x, c3, y;
        int     n;
        s         = (edges >= 2) ? cmp_hist[edges-2] : 1'b0;
        exp_valid = 1'b0;
        if ((edges % R) == R - 1) begin
            dec_i3.push_back(i3);
            n  = dec_i3.size();
            c3 = dv(n-1) - 3 * dv(n-2) + 3 * dv(n-3) - dv(n-4);
`ifdef DS_DEC_ROUND_EN
            y = (c3 + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`else
            y = c3 >>> SHIFT;
`endif
            if (ticks >= 3) begin
                exp_valid = 1'b1;
                exp_sat   = (y > Y_MAX) || (y < Y_MIN);
                if (y > Y_MAX) y = Y_MAX;
                if (y < Y_MIN) y = Y_MIN;
                exp_sample = ds_sample_t'(y);
            end
            ticks++;
        end
        x  = s ? 64'sd1 : -64'sd1;
        i3 = i3 + i2;
        i2 = i2 + i1;
        i1 = i1 + x;
        exp_fb = (edges >= 1) ? cmp_hist[edges-1] : 1'b0;
        cmp_hist.push_back(cmp_in);
        edges++;
    endtask

    task automatic compare_outputs();
        check("sample_valid", sample_valid, exp_valid);
        check("sample_out", sample_out, exp_sample);
        check("sat", sat, exp_sat);
        check("fb_out", fb_out, exp_fb);
    endtask

    // ---------------- strobe tracking with literal expectations ----------------
    int     mode;
    int     settle;
    int     strobe_cnt;
    int     first_edge;
    int     last_edge;
    longint lo, hi;
    bit     exp_sat_lit;
    longint acc;
    longint mod_u;

    task automatic track_strobe();
        if (sample_valid === 1'b1) begin
            if (strobe_cnt == 0) first_edge = edges;
            else check("strobe_spacing", edges - last_edge, R);
            last_edge = edges;
            strobe_cnt++;
            if (strobe_cnt >= settle) begin
                check_range("strobe_sample", sample_out, lo, hi);
                check("strobe_sat", sat, exp_sat_lit);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic run_cycle(input bit c);
        cmp_in = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
        track_strobe();
    endtask

    task automatic clear_tracking();
        strobe_cnt = 0;
        first_edge = -1;
        last_edge  = 0;
        acc        = 0;
    endtask

    task automatic start_test(input int m, input int st, input longint l,
                              input longint h, input bit sat_lit);
        clrn = 1'b0;
        model_reset();
        clear_tracking();
        mode        = m;
        settle      = st;
        lo          = l;
        hi          = h;
        exp_sat_lit = sat_lit;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic run_test(input int ncycles);
        bit c;
        for (int k = 0; k < ncycles; k++) begin
            case (mode)
                1:       c = 1'b1;
                2:       c = 1'b0;
                3:       c = k[0];
                4: begin
                    acc = acc + mod_u - (fb_out ? 64'sd128 : -64'sd128);
                    c   = (acc >= 0);
                end
                default: c = ((k % 8) < 5);
            endcase
            run_cycle(c);
            if (mode == 1 && edges == 1) check("t1_fb_after_1clk", fb_out, 0);
            if (mode == 1 && edges == 2) check("t1_fb_after_2clk", fb_out, 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mode = 0;
        model_reset();
        clear_tracking();

        // Reset state.
        #2 clrn = 1'b0;
        @(negedge clk);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sat", sat, 0);
        check("rst_fb_out", fb_out, 0);

        // Full-scale positive: clamps to +127 with sat.
        start_test(1, 2, 127, 127, 1'b1);
        run_test(512);
        check("t1_first_strobe_edge", first_edge, 256);
        check("t1_strobe_count", strobe_cnt, 5);

        // Full-scale negative: -128 exactly, no clamp.
        start_test(2, 2, -128, -128, 1'b0);
        run_test(532);
        check("t2_strobe_count", strobe_cnt, 5);
        check("t2_held_sample", sample_out, -128);

        // Mid-period reset: outputs drop at once, warm-up repeats.
        #2 clrn = 1'b0;
        #1;
        check("midrst_sample_out", sample_out, 0);
        check("midrst_sample_valid", sample_valid, 0);
        check("midrst_sat", sat, 0);
        check("midrst_fb_out", fb_out, 0);
        model_reset();
        clear_tracking();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        run_test(300);
        check("midrst_first_strobe_edge", first_edge, 256);
        check("midrst_strobe_count", strobe_cnt, 1);

        // Alternating bits: mid-scale, -1 or 0.
        start_test(3, 1, -1, 0, 1'b0);
        run_test(512);
        check("t3_strobe_count", strobe_cnt, 5);

        // Closed loop through a first-order modulator at +64.
        mod_u = 64;
        start_test(4, 12, 63, 65, 1'b0);
        run_test(1536);
        check("t4p_strobe_count", strobe_cnt, 21);

        // Closed loop at -100.
        mod_u = -100;
        start_test(4, 12, -101, -99, 1'b0);
        run_test(1536);
        check("t4n_strobe_count", strobe_cnt, 21);

        // Duty cycle 5/8: mean +1/4 of full scale.
`ifdef DS_DEC_ROUND_EN
        start_test(6, 2, 32, 32, 1'b0);
`else
        start_test(6, 2, 31, 32, 1'b0);
`endif
        run_test(512);
        check("t6_strobe_count", strobe_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
